// File: rtl/inv_sub_nibble_engine_pkg.sv
// rtl/inv_sub_nibble_engine_pkg.sv - shared sbox tables, nibble permutation and FSM state type
package inv_sub_nibble_engine_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Nibble x of each table holds the mapped value of x; nibble i of PERM_TBL holds P[i].
    localparam logic [63:0] SBOX_TBL     = 64'h2174_8FE3_DA09_B65C;
    localparam logic [63:0] INV_SBOX_TBL = 64'hA970_364B_D21C_8FE5;
    localparam logic [63:0] PERM_TBL     = 64'hF852_B41E_70DA_3C96;

    function automatic logic [3:0] sbox(input logic [3:0] x);
        return SBOX_TBL[{x, 2'b00} +: 4];
    endfunction

    function automatic logic [3:0] inv_sbox(input logic [3:0] x);
        return INV_SBOX_TBL[{x, 2'b00} +: 4];
    endfunction

    function automatic logic [3:0] perm_idx(input int i);
        return PERM_TBL[i*4 +: 4];
    endfunction

    function automatic logic [63:0] sub_nibble(input logic [63:0] x);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            r[i*4 +: 4] = sbox(x[perm_idx(i)*4 +: 4]);
        end
        return r;
    endfunction

endpackage

// File: rtl/inv_sub_nibble_engine_if.sv
// rtl/inv_sub_nibble_engine_if.sv - block input/output handshake bundle
interface inv_sub_nibble_engine_if;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic [63:0] in_key;
    logic [3:0]  in_rounds;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic        busy;

    modport master (
        output in_valid, in_data, in_key, in_rounds, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  in_valid, in_data, in_key, in_rounds, out_ready,
        output in_ready, out_valid, out_data, busy
    );
endinterface

// File: rtl/inv_sub_nibble_engine_round.sv
// rtl/inv_sub_nibble_engine_round.sv - one combinational inverse round: unkey, unpermute, inverse sbox
module inv_nibble_round
    import inv_sub_nibble_engine_pkg::*;
(
    input  logic [63:0] state,
    input  logic [63:0] key,
    output logic [63:0] result
);

    logic [63:0] t;
    logic [63:0] u;

    assign t = state ^ key;

    always_comb begin
        u      = '0;
        result = '0;
        // Undo the forward gather: nibble i came from input nibble P[i].
        for (int i = 0; i < 16; i++) begin
            u[perm_idx(i)*4 +: 4] = t[i*4 +: 4];
        end
        for (int k = 0; k < 16; k++) begin
            result[k*4 +: 4] = inv_sbox(u[k*4 +: 4]);
        end
    end

endmodule

// File: rtl/inv_sub_nibble_engine.sv
// rtl/inv_sub_nibble_engine.sv - iterative inverse SubNibble engine, one round per clock
module inv_sub_nibble_engine
    import inv_sub_nibble_engine_pkg::*;
#(
    parameter int MAX_ROUNDS = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    inv_sub_nibble_engine_if.slave bus
);

    localparam logic [4:0] MAX_R = 5'(MAX_ROUNDS);

    state_t      st, st_nx;
    logic        live;
    logic [63:0] data_q, key_q, round_out;
    logic [4:0]  cnt_q, req_rounds, eff_rounds;
    logic        ready, accept;

    assign req_rounds = (bus.in_rounds == 4'd0) ? 5'd16 : {1'b0, bus.in_rounds};
    assign eff_rounds = (req_rounds > MAX_R) ? MAX_R : req_rounds;
    assign accept     = bus.in_valid && ready;

    inv_nibble_round u_round (
        .state  (data_q),
        .key    (key_q),
        .result (round_out)
    );

    // live holds in_ready low until the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st   <= ST_IDLE;
            live <= 1'b0;
        end else begin
            st   <= st_nx;
            live <= 1'b1;
        end
    end

    always_comb begin
        st_nx = st;
        case (st)
            ST_IDLE: if (accept)              st_nx = ST_RUN;
            ST_RUN:  if (cnt_q == 5'd1)       st_nx = ST_DONE;
            ST_DONE: if (bus.out_ready)       st_nx = ST_IDLE;
            default:                          st_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        ready        = live && (st == ST_IDLE);
        bus.in_ready = ready;
        bus.busy     = (st == ST_RUN);
        bus.out_valid = (st == ST_DONE);
        bus.out_data = (st == ST_DONE) ? data_q : 64'd0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            key_q  <= '0;
            cnt_q  <= '0;
        end else if (accept) begin
            data_q <= bus.in_data;
            key_q  <= bus.in_key;
            cnt_q  <= eff_rounds;
        end else if (st == ST_RUN) begin
            data_q <= round_out;
            cnt_q  <= cnt_q - 5'd1;
        end
    end

endmodule

// File: tb/tb_inv_sub_nibble_engine.sv
// tb/tb_inv_sub_nibble_engine.sv - scoreboard bench for inv_sub_nibble_engine
module tb_inv_sub_nibble_engine;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    inv_sub_nibble_engine_if bus16 ();
    inv_sub_nibble_engine_if bus8 ();

    inv_sub_nibble_engine #(.MAX_ROUNDS(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16.slave));
    inv_sub_nibble_engine #(.MAX_ROUNDS(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8.slave));

    int n_chk = 0;
    int n_err = 0;
    logic [63:0] q16[$];
    logic [63:0] q8[$];

    int bsb[16] = '{12, 5, 6, 11, 9, 0, 10, 13, 3, 14, 15, 8, 4, 7, 1, 2};
    int bp[16]  = '{6, 9, 12, 3, 10, 13, 0, 7, 14, 1, 4, 11, 2, 5, 8, 15};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] enc(input logic [63:0] x, input logic [63:0] k, input int n);
        logic [63:0] s, r;
        s = x;
        for (int j = 0; j < n; j++) begin
            r = '0;
            for (int i = 0; i < 16; i++) r[i*4 +: 4] = 4'(bsb[s[bp[i]*4 +: 4]]);
            s = r ^ k;
        end
        return s;
    endfunction

    always @(negedge clk) begin
        if (bus16.out_valid && bus16.out_ready) begin
            if (q16.size() == 0) check("sb16_empty", 64'd1, 64'd0);
            else check("sb16_data", bus16.out_data, q16.pop_front());
        end
        if (!bus16.out_valid) check("zero16", bus16.out_data, 64'd0);
        if (bus8.out_valid && bus8.out_ready) begin
            if (q8.size() == 0) check("sb8_empty", 64'd1, 64'd0);
            else check("sb8_data", bus8.out_data, q8.pop_front());
        end
        if (!bus8.out_valid) check("zero8", bus8.out_data, 64'd0);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send16(input logic [63:0] d, input logic [63:0] k, input logic [3:0] r,
                          input logic [63:0] exp);
        int n = 0;
        while (!bus16.in_ready && n < 50) begin step(); n++; end
        check("in_ready_wait", 64'(bus16.in_ready), 64'd1);
        bus16.in_valid  = 1'b1;
        bus16.in_data   = d;
        bus16.in_key    = k;
        bus16.in_rounds = r;
        q16.push_back(exp);
        step();
        bus16.in_valid  = 1'b0;
        bus16.in_key    = {$urandom, $urandom};
        bus16.in_rounds = 4'($urandom);
    endtask

    task automatic wait_out16(input int exp_lat, input string tag);
        int lat = 0;
        int bz = 0;
        while (!bus16.out_valid && lat < 40) begin
            if (bus16.busy) bz++;
            step();
            lat++;
        end
        check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        check({tag, "_busy"}, 64'(bz), 64'(exp_lat));
    endtask

    task automatic drain16();
        bus16.out_ready = 1'b1;
        step();
        bus16.out_ready = 1'b0;
        check("ready_after_hs", 64'(bus16.in_ready), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [63:0] x, k, hold;
        int lat;
        bus16.in_valid = 0; bus16.in_data = 0; bus16.in_key = 0; bus16.in_rounds = 0; bus16.out_ready = 0;
        bus8.in_valid = 0;  bus8.in_data = 0;  bus8.in_key = 0;  bus8.in_rounds = 0;  bus8.out_ready = 0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 64'(bus16.in_ready), 64'd0);
        check("rst_out_valid", 64'(bus16.out_valid), 64'd0);
        check("rst_busy", 64'(bus16.busy), 64'd0);
        check("rst_out_data", bus16.out_data, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_in_ready_pre", 64'(bus16.in_ready), 64'd0);
        step();
        check("rel_in_ready_post", 64'(bus16.in_ready), 64'd1);

        // single round, zero key
        x = 64'h0123456789ABCDEF;
        send16(enc(x, 64'd0, 1), 64'd0, 4'd1, x);
        wait_out16(1, "n1");
        drain16();

        // 16 rounds via in_rounds=0
        x = 64'hDEADBEEFCAFEF00D;
        k = 64'hFEDCBA9876543210;
        send16(enc(x, k, 16), k, 4'd0, x);
        wait_out16(16, "n16");
        drain16();

        // consumer stall in DONE with a competing in_valid
        x = {$urandom, $urandom};
        k = {$urandom, $urandom};
        send16(enc(x, k, 3), k, 4'd3, x);
        wait_out16(3, "stall");
        hold = bus16.out_data;
        for (int c = 0; c < 5; c++) begin
            bus16.in_valid = 1'b1;
            bus16.in_data  = {$urandom, $urandom};
            step();
            check("stall_data", bus16.out_data, hold);
            check("stall_in_ready", 64'(bus16.in_ready), 64'd0);
            check("stall_valid", 64'(bus16.out_valid), 64'd1);
        end
        bus16.in_valid = 1'b0;
        drain16();
        step();
        check("stall_no_accept", 64'(bus16.busy), 64'd0);

        // reset during round 3 of 8
        x = {$urandom, $urandom};
        k = {$urandom, $urandom};
        send16(enc(x, k, 8), k, 4'd8, x);
        step();
        step();
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 64'(bus16.busy), 64'd0);
        check("mid_rst_in_ready", 64'(bus16.in_ready), 64'd0);
        check("mid_rst_valid", 64'(bus16.out_valid), 64'd0);
        check("mid_rst_data", bus16.out_data, 64'd0);
        q16.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        check("mid_rel_pre", 64'(bus16.in_ready), 64'd0);
        step();
        check("mid_rel_post", 64'(bus16.in_ready), 64'd1);
        x = {$urandom, $urandom};
        k = {$urandom, $urandom};
        send16(enc(x, k, 5), k, 4'd5, x);
        wait_out16(5, "fresh");
        drain16();

        // back-to-back blocks
        x = {$urandom, $urandom};
        k = {$urandom, $urandom};
        send16(enc(x, k, 2), k, 4'd2, x);
        wait_out16(2, "b2b_a");
        x = {$urandom, $urandom};
        k = {$urandom, $urandom};
        bus16.out_ready = 1'b1;
        bus16.in_valid  = 1'b1;
        bus16.in_data   = enc(x, k, 3);
        bus16.in_key    = k;
        bus16.in_rounds = 4'd3;
        q16.push_back(x);
        step();
        check("b2b_hs_valid", 64'(bus16.out_valid), 64'd0);
        check("b2b_hs_ready", 64'(bus16.in_ready), 64'd1);
        step();
        check("b2b_accept_busy", 64'(bus16.busy), 64'd1);
        bus16.in_valid  = 1'b0;
        bus16.out_ready = 1'b0;
        bus16.in_key    = {$urandom, $urandom};
        wait_out16(3, "b2b_b");
        drain16();

        // clamp on the MAX_ROUNDS=8 instance
        x = {$urandom, $urandom};
        k = {$urandom, $urandom};
        check("m8_in_ready", 64'(bus8.in_ready), 64'd1);
        bus8.in_valid  = 1'b1;
        bus8.in_data   = enc(x, k, 8);
        bus8.in_key    = k;
        bus8.in_rounds = 4'hF;
        q8.push_back(x);
        step();
        bus8.in_valid  = 1'b0;
        bus8.in_rounds = 4'd1;
        lat = 0;
        while (!bus8.out_valid && lat < 40) begin step(); lat++; end
        check("m8_lat", 64'(lat), 64'd8);
        bus8.out_ready = 1'b1;
        step();
        bus8.out_ready = 1'b0;

        step();
        check("sb16_left", 64'(q16.size()), 64'd0);
        check("sb8_left", 64'(q8.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
